pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline-stage register, the next generation of the fixed-field inter-stage register between decode and execute. Carries an opaque payload bus with valid/ready handshakes on both sides. A 2-entry skid buffer sustains full throughput under back-pressure. Flush inserts bubbles by zeroing the payload. Instantiated between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

---
 rtl/pipe_stage_buf.sv | 126 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: 2-entry skid buffer with valid/ready on both sides and a flush that zeroes the stage.
// Optional saturating stall/flush performance counters are enabled with `define PIPE_STAGE_PERF_EN.

// state | meaning
// EMPTY | nothing buffered, main register zero
// ONE   | main register holds the head entry
// FULL  | main holds head, skid holds second entry, upstream stalled

module pipe_stage_buf #(
    parameter int DATA_W = 150,
    parameter int CTRL_W = 5
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] CTRL_MASK = ~({DATA_W{1'b1}} << CTRL_W);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              push, pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign level     = state;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // main_q is already zero whenever EMPTY; the side-effect enables are gated
    // again so they can never leak out of a bubble.
    assign out_data = out_valid ? main_q : (main_q & ~CTRL_MASK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nxt = FULL;
                        skid_nxt  = in_data;
                    end else if (push && pop) begin
                        main_nxt  = in_data;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                        main_nxt  = '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = '0;
                    skid_nxt  = '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (state != EMPTY) && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus random traffic against a queue-based model.
// Counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.

module tb_pipe_stage_buf;

    localparam int DATA_W = 150;
    localparam int VW     = DATA_W + 4;
`ifdef PIPE_STAGE_PERF_EN
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        level;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    pipe_stage_buf #(
        .DATA_W(DATA_W),
        .CTRL_W(5)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .level    (level)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a FIFO of at most two accepted payloads.
    logic [DATA_W-1:0] mq[$];
    int exp_stall = 0;
    int exp_flush = 0;

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        repeat (5) d = (d << 32) | DATA_W'($urandom());
        return d;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [DATA_W-1:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        return {mq.size() != 0, mq.size() < 2, 2'(mq.size()), head};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {out_valid, in_ready, level, out_data};
    endfunction

    task automatic model_clear();
        mq.delete();
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic tick();
        int sz;
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            sz = mq.size();
`ifdef PIPE_STAGE_PERF_EN
            if (sz != 0 && !out_ready && exp_stall < CNT_MAX) exp_stall++;
            if (flush && sz != 0 && exp_flush < CNT_MAX) exp_flush++;
`endif
            if (sz != 0 && out_ready) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (sz < 2 && in_valid) mq.push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] zero_vec;
        logic [DATA_W-1:0] d;
        zero_vec = {1'b0, 1'b1, 2'd0, {DATA_W{1'b0}}};
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush     = 1'($urandom());
            in_valid  = 1'($urandom());
            out_ready = 1'($urandom());
            in_data   = rand_data();
            tick();
            n_checks++;
            if (dut_vec() !== zero_vec)
                $display("FAIL reset_hold[%0d]: got %h want %h", i, dut_vec(), zero_vec);
            else n_pass++;
        end
        rst = 1'b1;
        idle_inputs();
        d = rand_data();
        d[7:0] = 8'hA5;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (!(out_valid === 1'b1 && out_data === d) || dut_vec() !== exp_vec())
            $display("FAIL reset_first_push: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
        drain();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            in_valid  = 1'b1;
            in_data   = DATA_W'(i);
            out_ready = 1'b1;
            tick();
            n_checks++;
            if (out_data !== DATA_W'(i) || level !== 2'd1 || in_ready !== 1'b1 ||
                dut_vec() !== exp_vec())
                $display("FAIL stream[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] seen[$];
        logic [7:0] vals[3];
        vals = '{8'h11, 8'h22, 8'h33};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(vals[i]);
            tick();
        end
        n_checks++;
        if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== DATA_W'(8'h11) ||
            dut_vec() !== exp_vec())
            $display("FAIL backpressure_full: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
        seen.push_back(out_data);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) in_valid = 1'b0;
            tick();
            if (out_valid) seen.push_back(out_data);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL backpressure_drain[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (seen.size() != 3 || seen[0] !== DATA_W'(8'h11) || seen[1] !== DATA_W'(8'h22) ||
            seen[2] !== DATA_W'(8'h33))
            $display("FAIL backpressure_order: got %0d entries, want 11 22 33", seen.size());
        else n_pass++;
        drain();
    endtask

    task automatic test_flush_full();
        logic [VW-1:0] zero_vec;
        zero_vec = {1'b0, 1'b1, 2'd0, {DATA_W{1'b0}}};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) begin
            in_data = rand_data() | DATA_W'(5'h1F);
            tick();
        end
        flush   = 1'b1;
        in_data = DATA_W'(8'h44);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== zero_vec || dut_vec() !== exp_vec())
                $display("FAIL flush_full[%0d]: got %h want %h", i, dut_vec(), zero_vec);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_push_pop_one();
        in_valid  = 1'b1;
        in_data   = DATA_W'(8'h55);
        out_ready = 1'b0;
        tick();
        in_data   = DATA_W'(8'h66);
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_data !== DATA_W'(8'h66) || level !== 2'd1 || dut_vec() !== exp_vec())
            $display("FAIL push_pop_one: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(99) < 60);
            out_ready = ($urandom_range(99) < 55);
            flush     = ($urandom_range(99) < 6);
            in_data   = rand_data();
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                if (errs < 5)
                    $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
                errs++;
            end else n_pass++;
`ifdef PIPE_STAGE_PERF_EN
            n_checks++;
            if (stall_cnt !== CNT_W'(exp_stall) || flush_cnt !== CNT_W'(exp_flush))
                $display("FAIL random_cnt[%0d]: got %0d/%0d want %0d/%0d",
                         i, stall_cnt, flush_cnt, exp_stall, exp_flush);
            else n_pass++;
`endif
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) begin
            in_data = rand_data();
            tick();
        end
        #2 rst = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (dut_vec() !== {1'b0, 1'b1, 2'd0, {DATA_W{1'b0}}})
            $display("FAIL async_reset: got %h want cleared", dut_vec());
        else n_pass++;
`ifdef PIPE_STAGE_PERF_EN
        n_checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0)
            $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        else n_pass++;
`endif
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        tick();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        in_valid  = 1'b1;
        in_data   = rand_data();
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (stall_cnt !== CNT_W'(5) || flush_cnt !== CNT_W'(1))
            $display("FAIL perf_counts: got %0d/%0d want 5/1", stall_cnt, flush_cnt);
        else n_pass++;
        idle_inputs();
        in_valid = 1'b1;
        in_data  = rand_data();
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (stall_cnt !== {CNT_W{1'b1}} || stall_cnt !== CNT_W'(exp_stall))
            $display("FAIL perf_saturate: got %0d want %0d", stall_cnt, CNT_MAX);
        else n_pass++;
        drain();
    endtask
`endif

    initial begin
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_push_pop_one();
        test_random();
        test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
